// File: rtl/frame_color_classifier.sv
// frame_color_classifier: counts red/blue RGB332 pixels per frame and decides the debounced dominant colour at VSYNC rise.
// Latency: counts, COLOR and the COLOR_VALID/COLOR_CHANGE pulses are registered, visible 2 clocks after the VSYNC rising edge.
// Backpressure: none; the pixel stream never stalls, PIXEL_VALID only qualifies the current cycle.
// Ports: CLK / RESET_N (async, active-low); PIXEL_IN, PIXEL_VALID, VSYNC from the camera capture;
//        COLOR, COLOR_VALID, COLOR_CHANGE debounced result; RED_COUNT, BLUE_COUNT counts of the last completed frame.
module frame_color_classifier #(
   parameter int COUNT_W       = 16,
   parameter int RED_MIN       = 5,
   parameter int BLUE_MIN      = 2,
   parameter int MIN_PIXELS    = 1000,
   parameter int MARGIN        = 0,
   parameter int STABLE_FRAMES = 2
) (
   input  logic               CLK,
   input  logic               RESET_N,
   input  logic [7:0]         PIXEL_IN,
   input  logic               PIXEL_VALID,
   input  logic               VSYNC,
   output logic [1:0]         COLOR,
   output logic               COLOR_VALID,
   output logic               COLOR_CHANGE,
   output logic [COUNT_W-1:0] RED_COUNT,
   output logic [COUNT_W-1:0] BLUE_COUNT
);

   typedef enum logic [1:0] {
      ST_SYNC   = 2'd0,
      ST_ACCUM  = 2'd1,
      ST_DECIDE = 2'd2
   } state_t;

   localparam logic [1:0]         C_NONE   = 2'b00;
   localparam logic [1:0]         C_RED    = 2'b01;
   localparam logic [1:0]         C_BLUE   = 2'b10;
   localparam logic [2:0]         RED_THR  = 3'(RED_MIN);
   localparam logic [1:0]         BLUE_THR = 2'(BLUE_MIN);
   localparam logic [COUNT_W:0]   MIN_EXT  = (COUNT_W+1)'(MIN_PIXELS);
   localparam logic [COUNT_W:0]   MAR_EXT  = (COUNT_W+1)'(MARGIN);
   localparam logic [3:0]         RUN_MAX  = 4'(STABLE_FRAMES);
   localparam logic [COUNT_W-1:0] CNT_MAX  = '1;
   localparam logic [COUNT_W-1:0] CNT_ONE  = {{(COUNT_W-1){1'b0}}, 1'b1};

   state_t             state_q, state_d;
   logic               vsync_q, vsync_d;
   logic [COUNT_W-1:0] red_cnt_q, red_cnt_d;
   logic [COUNT_W-1:0] blue_cnt_q, blue_cnt_d;
   logic [COUNT_W-1:0] red_count_q, red_count_d;
   logic [COUNT_W-1:0] blue_count_q, blue_count_d;
   logic [1:0]         color_q, color_d;
   logic               color_valid_q, color_valid_d;
   logic               color_change_q, color_change_d;
   logic [1:0]         last_raw_q, last_raw_d;
   logic [3:0]         run_q, run_d;

   logic [2:0]         pix_r;
   logic [1:0]         pix_b;
   logic               green_unused;
   logic               is_red, is_blue, count_en, frame_end;
   logic [COUNT_W:0]   red_ext, blue_ext;
   logic [1:0]         raw;

   assign pix_r        = PIXEL_IN[7:5];
   assign pix_b        = PIXEL_IN[1:0];
   assign green_unused = ^PIXEL_IN[4:2];

   // Both conditions require the other channel below its threshold, so red and blue never overlap.
   assign is_red    = (pix_r >= RED_THR) && (pix_b < BLUE_THR);
   assign is_blue   = (pix_b >= BLUE_THR) && (pix_r < RED_THR);
   assign count_en  = PIXEL_VALID && !VSYNC;
   assign frame_end = VSYNC && !vsync_q;

   // One extra bit so count + MARGIN cannot wrap.
   assign red_ext  = {1'b0, red_cnt_q};
   assign blue_ext = {1'b0, blue_cnt_q};

   always_comb begin
      raw = C_NONE;
      if ((red_ext >= MIN_EXT) && (red_ext > blue_ext + MAR_EXT)) begin
         raw = C_RED;
      end else if ((blue_ext >= MIN_EXT) && (blue_ext > red_ext + MAR_EXT)) begin
         raw = C_BLUE;
      end
   end

   always_comb begin
      state_d        = state_q;
      vsync_d        = VSYNC;
      red_cnt_d      = red_cnt_q;
      blue_cnt_d     = blue_cnt_q;
      red_count_d    = red_count_q;
      blue_count_d   = blue_count_q;
      color_d        = color_q;
      color_valid_d  = 1'b0;
      color_change_d = 1'b0;
      last_raw_d     = last_raw_q;
      run_d          = run_q;

      unique case (state_q)
         ST_SYNC: begin
            // Partial frame after reset: nothing is counted.
            red_cnt_d  = '0;
            blue_cnt_d = '0;
            if (frame_end) begin
               state_d = ST_ACCUM;
            end
         end

         ST_ACCUM: begin
            if (count_en && is_red && (red_cnt_q != CNT_MAX)) begin
               red_cnt_d = red_cnt_q + CNT_ONE;
            end
            if (count_en && is_blue && (blue_cnt_q != CNT_MAX)) begin
               blue_cnt_d = blue_cnt_q + CNT_ONE;
            end
            if (frame_end) begin
               state_d = ST_DECIDE;
            end
         end

         ST_DECIDE: begin
            red_count_d   = red_cnt_q;
            blue_count_d  = blue_cnt_q;
            color_valid_d = 1'b1;
            // After a one-cycle VSYNC pulse a pixel may already arrive here;
            // it belongs to the new frame, so it seeds the cleared counter.
            red_cnt_d  = (count_en && is_red)  ? CNT_ONE : '0;
            blue_cnt_d = (count_en && is_blue) ? CNT_ONE : '0;

            if (raw == last_raw_q) begin
               run_d = (run_q == RUN_MAX) ? run_q : run_q + 4'd1;
            end else begin
               run_d      = 4'd1;
               last_raw_d = raw;
            end
            // last_raw_d equals raw on both branches above.
            if ((run_d == RUN_MAX) && (raw != color_q)) begin
               color_d        = raw;
               color_change_d = 1'b1;
            end
            state_d = ST_ACCUM;
         end

         default: begin
            state_d = ST_SYNC;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q        <= ST_SYNC;
         vsync_q        <= 1'b0;
         red_cnt_q      <= '0;
         blue_cnt_q     <= '0;
         red_count_q    <= '0;
         blue_count_q   <= '0;
         color_q        <= C_NONE;
         color_valid_q  <= 1'b0;
         color_change_q <= 1'b0;
         last_raw_q     <= C_NONE;
         run_q          <= 4'd0;
      end else begin
         state_q        <= state_d;
         vsync_q        <= vsync_d;
         red_cnt_q      <= red_cnt_d;
         blue_cnt_q     <= blue_cnt_d;
         red_count_q    <= red_count_d;
         blue_count_q   <= blue_count_d;
         color_q        <= color_d;
         color_valid_q  <= color_valid_d;
         color_change_q <= color_change_d;
         last_raw_q     <= last_raw_d;
         run_q          <= run_d;
      end
   end

   assign COLOR        = color_q;
   assign COLOR_VALID  = color_valid_q;
   assign COLOR_CHANGE = color_change_q;
   assign RED_COUNT    = red_count_q;
   assign BLUE_COUNT   = blue_count_q;

endmodule
